// File: rtl/pcie_rst_seq_pkg.sv
// pcie_rst_seq_pkg: shared types and constants for the PCIe reset sequencer.
// Holds the FSM state encoding (also visible in STATUS), the CSR offsets and
// the CTRL bit positions, plus the per-state reset mask.
package pcie_rst_seq_pkg;

   typedef enum logic [2:0] {
      HOLD   = 3'd0,
      WAIT_A = 3'd1,
      WAIT_B = 3'd2,
      WAIT_C = 3'd3,
      DONE   = 3'd4
   } seq_state_t;

   localparam logic [4:0] CTRL_OFS   = 5'd0;
   localparam logic [4:0] DELAY_OFS  = 5'd1;
   localparam logic [4:0] STATUS_OFS = 5'd2;

   localparam int CTRL_SW_LSB      = 0;
   localparam int CTRL_SW_MSB      = 2;
   localparam int CTRL_RESTART_BIT = 3;
   localparam int CTRL_BUSY_BIT    = 7;

   localparam int STATUS_PG_DROP_BIT = 4;

   // Ports still held by the sequencer in a given state (bit 0 = A).
   function automatic logic [2:0] seq_mask(seq_state_t s);
      case (s)
         HOLD, WAIT_A: return 3'b111;
         WAIT_B:       return 3'b110;
         WAIT_C:       return 3'b100;
         DONE:         return 3'b000;
         default:      return 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/pcie_rst_seq_tick_downcnt.sv
// tick_downcnt: 8-bit loadable down-counter advanced by a tick enable.
// Priority is clr, then load, then a decrement on ce. The count stops at
// zero instead of wrapping, so zero stays asserted until the next load.
module tick_downcnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic       load,
   input  logic       clr,
   input  logic [7:0] load_val,
   output logic       zero
);

   logic [7:0] count;

   // Count register: clear, reload, or decrement once per tick while nonzero.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n)
         count <= 8'd0;
      else if (clr)
         count <= 8'd0;
      else if (load)
         count <= load_val;
      else if (ce && (count != 8'd0))
         count <= count - 8'd1;
   end

   assign zero = (count == 8'd0);

endmodule

// File: rtl/pcie_rst_seq.sv
// pcie_rst_seq: releases PCIe resets A, B, C in turn after power-good,
// spaced by DELAY+1 ce ticks, with software hold and restart via CSRs.
// Optional feature macro: PCIE_RST_SEQ_STATUS_EN adds the STATUS register
// (FSM state and a sticky pg_drop flag) at BASE_ADDR+2.
module pcie_rst_seq
   import pcie_rst_seq_pkg::*;
#(
   parameter logic [4:0] BASE_ADDR     = 5'h0,
   parameter logic [7:0] DEFAULT_DELAY = 8'd32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic [4:0] csr_a,
   input  logic [7:0] csr_di,
   input  logic       csr_we,
   output logic [7:0] csr_do,
   input  logic       pwr_good,
   output logic [2:0] pcie_rst
);

   localparam logic [4:0] CTRL_ADDR  = BASE_ADDR + CTRL_OFS;
   localparam logic [4:0] DELAY_ADDR = BASE_ADDR + DELAY_OFS;

   seq_state_t state;
   logic [2:0] sw_assert;
   logic [2:0] sw_assert_nxt;
   logic [7:0] delay_q;
   logic       restart_pend;
   logic       sel_ctrl;
   logic       sel_delay;
   logic       wr_ctrl;
   logic       wr_delay;
   logic       restart_wr;
   logic       busy;
   logic       cnt_load;
   logic       cnt_clr;
   logic       cnt_zero;
   logic       unused_csr_di;

   assign sel_ctrl   = (csr_a == CTRL_ADDR);
   assign sel_delay  = (csr_a == DELAY_ADDR);
   assign wr_ctrl    = csr_we && sel_ctrl;
   assign wr_delay   = csr_we && sel_delay;
   assign restart_wr = wr_ctrl && csr_di[CTRL_RESTART_BIT];

   assign sw_assert_nxt = wr_ctrl ? csr_di[CTRL_SW_MSB:CTRL_SW_LSB] : sw_assert;
   assign busy          = (state == WAIT_A) || (state == WAIT_B) || (state == WAIT_C);

   assign unused_csr_di = &{1'b0, csr_di[7:4]};

   // Counter loads DELAY on every entry into a WAIT state and is cleared
   // whenever the sequence is forced back to HOLD.
   assign cnt_clr  = !pwr_good || restart_wr;
   assign cnt_load = !cnt_clr &&
                     (((state == HOLD) && !restart_pend) ||
                      (ce && cnt_zero && ((state == WAIT_A) || (state == WAIT_B))));

   tick_downcnt u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (ce),
      .load     (cnt_load),
      .clr      (cnt_clr),
      .load_val (delay_q),
      .zero     (cnt_zero)
   );

   // CSR storage: software hold bits and the release delay.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_assert <= 3'b000;
         delay_q   <= DEFAULT_DELAY;
      end else begin
         sw_assert <= sw_assert_nxt;
         if (wr_delay)
            delay_q <= csr_di;
      end
   end

   // Sequencer FSM; pcie_rst is registered from the next state's mask so the
   // output lines come straight from flops.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= HOLD;
         restart_pend <= 1'b0;
         pcie_rst     <= 3'b111;
      end else begin
         pcie_rst <= seq_mask(state) | sw_assert_nxt;

         if (restart_wr)
            restart_pend <= 1'b1;
         else if (ce)
            restart_pend <= 1'b0;

         if (!pwr_good || restart_wr) begin
            state    <= HOLD;
            pcie_rst <= 3'b111;
         end else begin
            case (state)
               HOLD:
                  if (!restart_pend)
                     state <= WAIT_A;
               WAIT_A:
                  if (ce && cnt_zero) begin
                     state    <= WAIT_B;
                     pcie_rst <= seq_mask(WAIT_B) | sw_assert_nxt;
                  end
               WAIT_B:
                  if (ce && cnt_zero) begin
                     state    <= WAIT_C;
                     pcie_rst <= seq_mask(WAIT_C) | sw_assert_nxt;
                  end
               WAIT_C:
                  if (ce && cnt_zero) begin
                     state    <= DONE;
                     pcie_rst <= seq_mask(DONE) | sw_assert_nxt;
                  end
               DONE: ;
               default: begin
                  state    <= HOLD;
                  pcie_rst <= 3'b111;
               end
            endcase
         end
      end
   end

`ifdef PCIE_RST_SEQ_STATUS_EN
   localparam logic [4:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;

   logic sel_status;
   logic pg_drop;

   assign sel_status = (csr_a == STATUS_ADDR);

   // Sticky power-good drop flag; a new drop wins over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n)
         pg_drop <= 1'b0;
      else if (!pwr_good && (state != HOLD))
         pg_drop <= 1'b1;
      else if (csr_we && sel_status && csr_di[STATUS_PG_DROP_BIT])
         pg_drop <= 1'b0;
   end
`endif

   // Read mux; returns zero when no register of this block is addressed.
   always_comb begin
      // NOTE: default assignment first so no path leaves csr_do unassigned
      // and no latch is inferred.
      csr_do = 8'h00;
      if (sel_ctrl) begin
         csr_do[CTRL_BUSY_BIT]           = busy;
         csr_do[CTRL_SW_MSB:CTRL_SW_LSB] = sw_assert;
      end else if (sel_delay) begin
         csr_do = delay_q;
      end
`ifdef PCIE_RST_SEQ_STATUS_EN
      else if (sel_status) begin
         csr_do[STATUS_PG_DROP_BIT] = pg_drop;
         csr_do[2:0]                = state;
      end
`endif
   end

endmodule

// File: doc/pcie_rst_seq.md
# pcie_rst_seq

PCIe reset sequencer on the board-control CSR bus, alongside misc_ctrl and the GPO blocks. After power-good it releases the PCIe A, B and C resets one after another, spaced by a programmable number of `ce` ticks. Software can hold any port in reset, or restart the whole sequence, through the I2C-mapped CSRs. Outputs are active-high reset requests; the top level inverts them onto `PCIE_x_RST_n`.

## Interface
Parameters:
- `BASE_ADDR`, `5'h0`: CSR base address; the block uses offsets +0, +1 and +2.
- `DEFAULT_DELAY`, `8'd32`: reset value of the DELAY register (about 1 ms with `ce_32khz`).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ce`  in  1  single-cycle tick enable (`ce_32khz`).
- `csr_a`  in  5  CSR address.
- `csr_di`  in  8  CSR write data.
- `csr_we`  in  1  CSR write strobe, one cycle.
- `csr_do`  out  8  CSR read data; `8'h00` when not addressed (the top ORs all blocks).
- `pwr_good`  in  1  synchronised power-good level.
- `pcie_rst`  out  3  reset request per port, bit 0 = A, bit 2 = C; 1 = hold in reset.

## Operation
Registers:
- CTRL (+0)
  - [2:0] `sw_assert` (RW, reset 0).
  - [3] `restart` (write-1 self-clearing, reads 0).
  - [7] `busy` (RO, 1 in any WAIT state).
  - Other bits read 0.
- DELAY (+1): RW, 8 bits, reset `DEFAULT_DELAY`.
- STATUS (+2): see Configuration.

FSM states: HOLD, WAIT_A, WAIT_B, WAIT_C, DONE.
- HOLD: `seq_rst = 3'b111`. On `pwr_good == 1` and no restart pending, go to WAIT_A.
- On entering any WAIT state, the counter loads DELAY. On each `ce`:
  - counter == 0: release this port's `seq_rst` bit and advance (A→B→C→DONE).
  - otherwise: decrement the counter.
- A port is therefore released DELAY+1 `ce` ticks after its WAIT state is entered.
- DONE: `seq_rst = 3'b000`.
- From any state, `pwr_good == 0` forces HOLD, `seq_rst = 3'b111` and counter = 0 on the next clk. This has priority over a `ce` release in the same cycle.
- `restart` write from any state:
  - go to HOLD and set `seq_rst = 3'b111`;
  - HOLD is then held for at least one full `ce` tick (restart pending clears on the next `ce`) before WAIT_A can be entered.
- `pcie_rst = seq_rst | sw_assert`.
- A DELAY write during a WAIT state does not change the running count; it applies at the next load.

Boundaries:
- DELAY = 0: each port releases on the first `ce` of its state.
- DELAY = 255: 256 ticks per port. The counter never wraps because it only decrements when nonzero.
- `restart` and `pwr_good` falling in the same cycle: HOLD; restart is still pending.
- `sw_assert` set while in DONE: the port is reset immediately; the FSM is unaffected.

## Timing
- While `rst_n == 0`: state HOLD, `pcie_rst = 3'b111`, CTRL = 0, DELAY = `DEFAULT_DELAY`, counter = 0, STATUS = 0.
- `pcie_rst` is registered. It changes one clk after the qualifying `ce`, CSR write or `pwr_good` edge.
- `csr_do` is combinational from `csr_a` and the registered state, with zero wait states.
- CSR writes take effect at the next clk edge.

## Configuration
Macro: `PCIE_RST_SEQ_STATUS_EN`.
- Defined: STATUS (+2) is present.
  - [2:0] FSM state encoding.
  - [4] sticky `pg_drop`: set when `pwr_good` falls outside HOLD; write-1-to-clear.
  - Other bits 0.
- Undefined: offset +2 reads `8'h00`, writes are ignored, and no `pg_drop` flop is built.

## Structure
- Package `pcie_rst_seq_pkg`:
  - FSM state enum: HOLD = 0, WAIT_A = 1, WAIT_B = 2, WAIT_C = 3, DONE = 4;
  - register offsets `CTRL_OFS`, `DELAY_OFS`, `STATUS_OFS`;
  - CTRL bit-index constants.
- One sub-module, `tick_downcnt`: an 8-bit loadable down-counter with `ce`, `load`, `clr` and a `zero` flag.

## Test plan
Bench: `ce` every 4 clk, `BASE_ADDR = 5'h08`.

1. Reset, DELAY = 2, `pwr_good` rises: A releases 3 ticks after the rise, B 3 ticks after A, C 3 ticks after B; final `pcie_rst = 3'b000`; CTRL read = `8'h00`.
2. `pwr_good` drops while in WAIT_B: next clk `pcie_rst = 3'b111` and state HOLD. With the macro on, STATUS[4] = 1; writing `8'h10` to +2 clears it.
3. Write CTRL = `8'h05` while in DONE: `pcie_rst = 3'b101` next clk. Write `8'h00`: `pcie_rst = 3'b000`.
4. Write CTRL = `8'h08` while in DONE: immediate `3'b111`, `busy` = 1 after one `ce`, then full resequence; CTRL[3] reads 0.
5. DELAY = 0: each port releases 1 tick apart. DELAY = 255 written mid-WAIT_A: current count unaffected; WAIT_B takes 256 ticks.
6. Read at +3, and at +2 with the macro off: `csr_do = 8'h00`. Assert `rst_n` low mid-sequence: all outputs return to their reset values on the next clk.
